// File: rtl/cic_pkg.sv
// rtl/cic_pkg.sv - shared types, width helpers and parameter legality for the CIC interpolation scheduler
package cic_pkg;

  typedef enum logic [1:0] {
    PRIME = 2'd0,
    EMIT  = 2'd1,
    WAIT  = 2'd2
  } cic_sched_state_t;

  function automatic int phase_w(input int r);
    return (r > 1) ? $clog2(r) : 1;
  endfunction

  function automatic int prime_w(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

  function automatic bit params_legal(input int r, input int n);
    return (r >= 2) && (r <= 256) && (n >= 1);
  endfunction

endpackage

// File: rtl/cic_phase_counter.sv
// rtl/cic_phase_counter.sv - modulo-R phase counter with enable, terminal-count flag and load-zero
module cic_phase_counter #(
  parameter int R = 4,
  parameter int W = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic         i_clr,
  output logic [W-1:0] o_count,
  output logic         o_tc
);

  localparam logic [W-1:0] LAST = W'(R - 1);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= (r_count == LAST) ? '0 : r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == LAST);

endmodule

// File: rtl/cic_interp_scheduler.sv
// rtl/cic_interp_scheduler.sv - rate controller owning comb/integrator enables and zero-stuffing
module cic_interp_scheduler
  import cic_pkg::*;
#(
  parameter int R          = 4,
  parameter int N          = 3,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_in_valid,
  input  logic [DATA_WIDTH-1:0] i_in_data,
  output logic                  o_in_ready,
  output logic                  o_comb_en,
  output logic [DATA_WIDTH-1:0] o_comb_din,
  input  logic [DATA_WIDTH-1:0] i_comb_out,
  input  logic                  i_tick,
  output logic                  o_int_en,
  output logic [DATA_WIDTH-1:0] o_int_din,
  output logic                  o_out_valid,
  output logic                  o_underrun,
  input  logic                  i_underrun_clr
);

  localparam int PHASE_W = phase_w(R);
  localparam int PRIME_W = prime_w(N);
  localparam logic [PRIME_W-1:0] PRIME_LAST = PRIME_W'(N - 1);

  if (!params_legal(R, N)) begin : g_illegal_params
    $error("cic_interp_scheduler: R must be 2..256 and N must be >= 1");
  end

  cic_sched_state_t   r_state;
  logic [PRIME_W-1:0] r_prime_cnt;
  logic               r_out_valid;
  logic               r_underrun;

  logic [PHASE_W-1:0] w_phase;
  logic               w_tc;
  logic               w_in_ready;
  logic               w_int_en;
  logic               w_fwd;
  logic               w_underrun_set;
  logic               w_accept;

  always_comb begin
    w_in_ready     = 1'b0;
    w_int_en       = 1'b0;
    w_fwd          = 1'b0;
    w_underrun_set = 1'b0;
    case (r_state)
      PRIME: w_in_ready = 1'b1;
      EMIT: begin
        w_in_ready = i_tick & w_tc;
        w_int_en   = i_tick;
        w_fwd      = (w_phase == '0);
      end
      WAIT: begin
        w_in_ready     = 1'b1;
        w_int_en       = i_tick;
        w_underrun_set = i_tick;
      end
      default: w_in_ready = 1'b0;
    endcase
  end

  assign w_accept = i_in_valid & w_in_ready;

  // Phase wraps to 0 on its own after the last EMIT tick; the load only matters when entering EMIT.
  cic_phase_counter #(
    .R(R),
    .W(PHASE_W)
  ) u_phase (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    ((r_state == EMIT) & i_tick),
    .i_clr   ((r_state != EMIT) & w_accept),
    .o_count (w_phase),
    .o_tc    (w_tc)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state     <= PRIME;
      r_prime_cnt <= '0;
      r_out_valid <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_out_valid <= w_int_en;
      if (w_underrun_set) begin
        r_underrun <= 1'b1;
      end else if (i_underrun_clr) begin
        r_underrun <= 1'b0;
      end
      case (r_state)
        PRIME: begin
          if (w_accept) begin
            r_prime_cnt <= r_prime_cnt + 1'b1;
            if (r_prime_cnt == PRIME_LAST) begin
              r_state <= EMIT;
            end
          end
        end
        EMIT: begin
          if (i_tick && w_tc && !i_in_valid) begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (i_in_valid) begin
            r_state <= EMIT;
          end
        end
        default: r_state <= PRIME;
      endcase
    end
  end

  assign o_in_ready  = w_in_ready;
  assign o_comb_en   = w_accept;
  assign o_comb_din  = i_in_data;
  assign o_int_en    = w_int_en;
  assign o_int_din   = w_fwd ? i_comb_out : '0;
  assign o_out_valid = r_out_valid;
  assign o_underrun  = r_underrun;

endmodule

// File: doc/cic_interp_scheduler.md
# cic_interp_scheduler

Rate controller for the CIC interpolation filter. Accepts low-rate samples over a valid/ready handshake, issues one enable per accepted sample to the comb chain, and zero-stuffs comb output into the integrator chain at the high rate paced by `tick`. Sits between the sample source and the Comb/Integrator datapath and owns every enable in that datapath.

## Interface
- `R`, 4: interpolation ratio; legal range 2..256.
- `N`, 3: number of comb stages; also the priming depth in samples; N ≥ 1.
- `DATA_WIDTH`, 32: signed sample width.
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  source has a sample.
- `in_data`  in  DATA_WIDTH  signed input sample.
- `in_ready`  out  1  scheduler accepts `in_data` this cycle.
- `comb_en`  out  1  comb chain advance; equals `in_valid & in_ready`.
- `comb_din`  out  DATA_WIDTH  equals `in_data`.
- `comb_out`  in  DATA_WIDTH  last comb stage output (registered in datapath).
- `tick`  in  1  high-rate output strobe; one integrator step per tick.
- `int_en`  out  1  integrator chain advance.
- `int_din`  out  DATA_WIDTH  `comb_out` on phase 0, else 0.
- `out_valid`  out  1  integrator output updated; `int_en` delayed one cycle.
- `underrun`  out  1  sticky; a tick arrived with no sample available.
- `underrun_clr`  in  1  synchronous clear of `underrun`.

## Operation
- States: PRIME, EMIT, WAIT. `prime_cnt` counts 0..N. `phase` counts 0..R-1.
- Reset (rst low, asynchronous): state PRIME, `prime_cnt` 0, `phase` 0, `out_valid` 0, `underrun` 0. `in_ready` reads 1 (PRIME). `int_en` and `comb_en` are 0 unless driven by inputs.
- PRIME:
  - `in_ready` 1. Each accept increments `prime_cnt`.
  - `tick` is ignored: `int_en` 0, no underrun.
  - The N-th accept moves to EMIT with `phase` 0.
- EMIT:
  - `int_en = tick`.
  - `int_din = comb_out` if `phase == 0`, else 0.
  - On tick with `phase < R-1`: `phase` increments.
  - On tick with `phase == R-1`:
    - `in_ready` is 1 that cycle.
    - If `in_valid`: accept, `phase` goes to 0, stay in EMIT.
    - Else: go to WAIT.
  - `in_ready` is 0 on every other EMIT cycle.
- WAIT:
  - `in_ready` 1.
  - `in_valid` alone: accept, go to EMIT with `phase` 0. The tick for phase 0 comes later.
  - `tick` (with or without `in_valid`): `int_en` 1 with `int_din` 0, and `underrun` sets.
  - `in_valid` and `tick` in the same cycle: the zero step is issued, the sample is accepted, and the next state is EMIT with `phase` 0.
- `underrun`: set has priority over `underrun_clr` in the same cycle.
- Zero-stuff integrity: exactly one `comb_out` value is forwarded per accepted post-prime sample. The remaining R-1 phases are exactly 0.

## Timing
- `comb_en`, `in_ready`, `int_en` and `int_din` are combinational from state/`phase` and the inputs. No input-to-output path crosses more than one mux.
- `comb_out` changes the cycle after `comb_en`. EMIT phase 0 is never entered in the same cycle as its `comb_en`.
- `out_valid` asserts the cycle after `int_en`.
- First nonzero `int_din`: on the first tick after the N-th accept.
- Steady state with `in_valid` held high: one accept per R ticks, no bubbles.
- Reset mid-EMIT: `phase` and priming are discarded. The next run re-primes N samples.
- `tick` on consecutive cycles is legal. `R` ticks back-to-back complete one sample.

## Structure
- Package `cic_pkg`:
  - state enum `cic_sched_state_t` (PRIME, EMIT, WAIT).
  - `PHASE_W = $clog2(R)` and `PRIME_W = $clog2(N+1)` width helpers.
  - legality checks on R and N (elaboration-time).
- One sub-module `cic_phase_counter`:
  - modulo-R counter with enable, terminal-count flag and synchronous load-zero.
  - instantiated once for `phase`.

## Test plan
- Reset release, R=4, N=3, `in_valid` low, 5 ticks:
  - `in_ready` 1, `int_en` 0, `underrun` 0, `out_valid` 0 throughout.
- Priming, then ticks: samples 10, 20, 30 accepted with `in_valid` high.
  - Exactly 3 `comb_en` pulses.
  - The next 4 ticks give `int_din` = `comb_out`, 0, 0, 0.
  - `in_ready` rises only on the 4th tick.
- Continuous stream: `in_valid` always high, tick every cycle, 40 cycles.
  - One `comb_en` per 4 ticks.
  - `int_din` nonzero exactly on every 4th `int_en`.
  - `out_valid` equals `int_en` delayed one cycle.
- Starvation: `in_valid` dropped after priming, 6 ticks.
  - 4 EMIT phases, then WAIT.
  - Ticks 5 and 6 give `int_en` 1 with `int_din` 0, and `underrun` goes to 1.
  - `underrun_clr` plus a tick in the same cycle leaves `underrun` at 1.
  - `underrun_clr` alone clears it.
- Simultaneous event in WAIT: `in_valid` and `tick` in the same cycle.
  - Zero step issued and sample accepted.
  - The next tick forwards the new `comb_out`.
- Asynchronous reset asserted mid-EMIT at phase 2:
  - State returns to PRIME immediately, without a clock edge.
  - After release, 3 accepts are required before any nonzero `int_din`.
